// File: rtl/tte_pkg.sv
// rtl/tte_pkg.sv - shared types and constants for the truth-table evaluator
// Holds the FSM state type, the vector/fitness sizing helpers and the candidate input-bit positions.
package tte_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tte_state_e;

  localparam int TTE_N_IN = 4;

  // Candidate input letters: A is the vector MSB, D the LSB.
  localparam int BIT_A = TTE_N_IN - 1;
  localparam int BIT_B = TTE_N_IN - 2;
  localparam int BIT_C = TTE_N_IN - 3;
  localparam int BIT_D = 0;

  function automatic int calc_v(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic int calc_fw(input int n_in);
    return $clog2((1 << n_in) + 1);
  endfunction

endpackage

// File: rtl/tte_sample_delay.sv
// rtl/tte_sample_delay.sv - LAT-deep (valid, index) shift line
// Aligns the issued vector index with the candidate's output latency; LAT = 0 passes straight through.
module tte_sample_delay #(
  parameter int LAT = 0,
  parameter int IW  = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  logic [IW-1:0] i_idx,
  output logic          o_valid,
  output logic [IW-1:0] o_idx
);

  generate
    if (LAT == 0) begin : g_pass
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = i_clk ^ i_rst;
      assign o_valid = i_valid;
      assign o_idx   = i_idx;
    end else begin : g_line
      logic [LAT-1:0] r_vld;
      logic [IW-1:0]  r_idx [LAT];

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_vld <= '0;
          for (int i = 0; i < LAT; i++) r_idx[i] <= '0;
        end else begin
          r_vld[0] <= i_valid;
          r_idx[0] <= i_idx;
          for (int i = 1; i < LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_idx[i] <= r_idx[i-1];
          end
        end
      end

      assign o_valid = r_vld[LAT-1];
      assign o_idx   = r_idx[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/truth_table_evaluator.sv
// rtl/truth_table_evaluator.sv - sweeps a candidate circuit and scores its truth table
// Issues every input vector once, captures the candidate output per vector and counts matches against the target.
module truth_table_evaluator
  import tte_pkg::*;
#(
  parameter  int N_IN = TTE_N_IN,
  parameter  int LAT  = 0,
  localparam int V    = calc_v(N_IN),
  localparam int FW   = calc_fw(N_IN)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [V-1:0]    i_target,
  output logic [N_IN-1:0] o_vec_out,
  input  logic            i_dut_out,
  output logic            o_busy,
  output logic            o_done,
  output logic [V-1:0]    o_table_out,
  output logic [FW-1:0]   o_fitness,
  output logic            o_perfect
);

  localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] ONE_IDX  = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [FW-1:0]   FIT_MAX  = FW'(V);

  tte_state_e      r_state;
  logic [N_IN-1:0] r_issue_idx;
  logic [V-1:0]    r_target;
  logic [V-1:0]    r_table;
  logic [FW-1:0]   r_fitness;
  logic            r_busy;
  logic            r_done;
  logic            r_perfect;

  logic            w_issue_valid;
  logic            w_smp_valid;
  logic [N_IN-1:0] w_smp_idx;
  logic            w_smp_hit;
  logic            w_last_smp;
  logic [FW-1:0]   w_fit_next;

  assign w_issue_valid = (r_state == ST_SWEEP);

  tte_sample_delay #(
    .LAT (LAT),
    .IW  (N_IN)
  ) u_sample_delay (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (w_issue_valid),
    .i_idx   (r_issue_idx),
    .o_valid (w_smp_valid),
    .o_idx   (w_smp_idx)
  );

  assign w_smp_hit  = w_smp_valid && (i_dut_out == r_target[w_smp_idx]);
  assign w_fit_next = r_fitness + {{(FW-1){1'b0}}, w_smp_hit};
  // The final sample doubles as the end-of-evaluation marker for any latency.
  assign w_last_smp = w_smp_valid && (w_smp_idx == LAST_IDX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_issue_idx <= '0;
      r_target    <= '0;
      r_table     <= '0;
      r_fitness   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_perfect   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_smp_valid) begin
        r_table[w_smp_idx] <= i_dut_out;
        r_fitness          <= w_fit_next;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_target    <= i_target;
            r_table     <= '0;
            r_fitness   <= '0;
            r_perfect   <= 1'b0;
            r_issue_idx <= '0;
            r_busy      <= 1'b1;
            r_state     <= ST_SWEEP;
          end
        end
        ST_SWEEP, ST_DRAIN: begin
          if (w_last_smp) begin
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_perfect <= (w_fit_next == FIT_MAX);
          end else if (r_state == ST_SWEEP) begin
            if (r_issue_idx == LAST_IDX) begin
              r_state <= ST_DRAIN;
            end else begin
              r_issue_idx <= r_issue_idx + ONE_IDX;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_vec_out   = r_issue_idx;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_table_out = r_table;
  assign o_fitness   = r_fitness;
  assign o_perfect   = r_perfect;

endmodule

// File: tb/tb_truth_table_evaluator.sv
// tb/tb_truth_table_evaluator.sv - directed self-checking bench for truth_table_evaluator
// Drives a combinational stub (LAT=0) and a two-stage registered stub (LAT=2) with hand-computed expectations.
module tb_truth_table_evaluator;
  import tte_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start0 = 1'b0, start2 = 1'b0;
  logic [15:0] target0 = '0, target2 = '0;
  logic [3:0]  vec0, vec2;
  logic        dout0, dout2;
  logic        busy0, busy2, done0, done2, perf0, perf2;
  logic [15:0] table0, table2;
  logic [4:0]  fit0, fit2;

  logic        stub_zero = 1'b0;
  logic        cur_sel = 1'b0;
  logic        done_m;
  logic        p1, p2;
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt0 = 0;
  int          n, n2, base;

  always #5 clk = ~clk;

  truth_table_evaluator #(.N_IN(4), .LAT(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_target(target0),
    .o_vec_out(vec0), .i_dut_out(dout0), .o_busy(busy0), .o_done(done0),
    .o_table_out(table0), .o_fitness(fit0), .o_perfect(perf0)
  );

  truth_table_evaluator #(.N_IN(4), .LAT(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_target(target2),
    .o_vec_out(vec2), .i_dut_out(dout2), .o_busy(busy2), .o_done(done2),
    .o_table_out(table2), .o_fitness(fit2), .o_perfect(perf2)
  );

  // Out = (A|D)&~C&~(A&B), or constant 0
  always_comb begin
    dout0 = 1'b0;
    if (!stub_zero)
      dout0 = (vec0[BIT_A] | vec0[BIT_D]) & ~vec0[BIT_C] & ~(vec0[BIT_A] & vec0[BIT_B]);
  end

  always @(posedge clk) begin
    p1 <= vec2[BIT_A];
    p2 <= p1;
  end
  assign dout2 = p2;

  always_comb begin
    done_m = cur_sel ? done2 : done0;
  end

  always @(negedge clk) if (done0) done_cnt0++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic kick(input logic sel, input logic [15:0] tgt);
    cur_sel = sel;
    if (sel) begin target2 = tgt; start2 = 1'b1; end
    else     begin target0 = tgt; start0 = 1'b1; end
  endtask

  task automatic wait_done(input int budget, input bit chk_vec, output int cnt);
    cnt = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin start0 = 1'b0; start2 = 1'b0; end
      if (chk_vec && k <= 16) check_eq($sformatf("vec_seq_%0d", k - 1), 32'(vec0), 32'(k - 1));
      if (done_m) begin cnt = k; break; end
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) step();
    check_eq("rst_vec0", 32'(vec0), 0);
    check_eq("rst_busy0", 32'(busy0), 0);
    check_eq("rst_done0", 32'(done0), 0);
    check_eq("rst_table0", 32'(table0), 0);
    check_eq("rst_fit0", 32'(fit0), 0);
    check_eq("rst_perf0", 32'(perf0), 0);
    check_eq("rst_table2", 32'(table2), 0);
    check_eq("rst_busy2", 32'(busy2), 0);
    rst = 1'b0;
    step();

    // exact match, LAT=0
    kick(1'b0, 16'h0322);
    wait_done(40, 1'b1, n);
    check_eq("lat0_latency", n, 17);
    check_eq("lat0_table", 32'(table0), 32'h0322);
    check_eq("lat0_fit", 32'(fit0), 16);
    check_eq("lat0_perfect", 32'(perf0), 1);
    check_eq("lat0_busy_in_done", 32'(busy0), 0);
    step();
    check_eq("lat0_done_one_cycle", 32'(done0), 0);

    // same stub, all-zero target
    kick(1'b0, 16'h0000);
    wait_done(40, 1'b0, n);
    check_eq("t0_latency", n, 17);
    check_eq("t0_table", 32'(table0), 32'h0322);
    check_eq("t0_fit", 32'(fit0), 12);
    check_eq("t0_perfect", 32'(perf0), 0);
    step();

    // constant-0 stub against all-ones target
    stub_zero = 1'b1;
    kick(1'b0, 16'hFFFF);
    wait_done(40, 1'b0, n);
    check_eq("z_table", 32'(table0), 0);
    check_eq("z_fit", 32'(fit0), 0);
    check_eq("z_perfect", 32'(perf0), 0);
    stub_zero = 1'b0;
    step();

    // LAT=2 registered stub Out = A
    kick(1'b1, 16'hFF00);
    wait_done(40, 1'b0, n);
    check_eq("lat2_latency", n, 19);
    check_eq("lat2_table", 32'(table2), 32'hFF00);
    check_eq("lat2_fit", 32'(fit2), 16);
    check_eq("lat2_perfect", 32'(perf2), 1);
    step();

    // start pulses in SWEEP and DONE are ignored
    base = done_cnt0;
    kick(1'b0, 16'h0322);
    step(); start0 = 1'b0;
    step();
    step(); start0 = 1'b1; target0 = 16'h0000;
    step(); start0 = 1'b0;
    wait_done(40, 1'b0, n);
    check_eq("ign_latency", n + 4, 17);
    start0 = 1'b1;
    step(); start0 = 1'b0;
    check_eq("ign_busy_after_done", 32'(busy0), 0);
    repeat (20) step();
    check_eq("ign_done_count", done_cnt0 - base, 1);
    check_eq("ign_table_hold", 32'(table0), 32'h0322);
    check_eq("ign_fit_hold", 32'(fit0), 16);
    check_eq("ign_perf_hold", 32'(perf0), 1);
    kick(1'b0, 16'h0000);
    step(); start0 = 1'b0;
    check_eq("restart_table_clr", 32'(table0), 0);
    check_eq("restart_fit_clr", 32'(fit0), 0);
    check_eq("restart_perf_clr", 32'(perf0), 0);
    check_eq("restart_busy", 32'(busy0), 1);
    wait_done(40, 1'b0, n);
    check_eq("restart_latency", n + 1, 17);
    check_eq("restart_fit", 32'(fit0), 12);
    step();

    // reset in the 8th SWEEP cycle
    base = done_cnt0;
    kick(1'b0, 16'h0322);
    step(); start0 = 1'b0;
    repeat (7) step();
    check_eq("mid_vec_before_rst", 32'(vec0), 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_vec", 32'(vec0), 0);
    check_eq("mid_rst_busy", 32'(busy0), 0);
    check_eq("mid_rst_done", 32'(done0), 0);
    check_eq("mid_rst_table", 32'(table0), 0);
    check_eq("mid_rst_fit", 32'(fit0), 0);
    check_eq("mid_rst_perf", 32'(perf0), 0);
    repeat (25) step();
    check_eq("mid_rst_no_done", done_cnt0 - base, 0);
    kick(1'b0, 16'hFFFF);
    wait_done(40, 1'b0, n);
    check_eq("post_rst_latency", n, 17);
    check_eq("post_rst_table", 32'(table0), 32'h0322);
    check_eq("post_rst_fit", 32'(fit0), 4);

    // back-to-back: first done -> start in first IDLE cycle
    step();
    kick(1'b0, 16'h0322);
    wait_done(40, 1'b0, n);
    check_eq("b2b_first_fit", 32'(fit0), 16);
    step();
    kick(1'b0, 16'h0000);
    wait_done(40, 1'b0, n2);
    check_eq("b2b_gap", n2 + 1, 18);
    check_eq("b2b_second_fit", 32'(fit0), 12);
    check_eq("b2b_second_perf", 32'(perf0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
